// File: rtl/cram_port_arbiter.sv
// cram_port_arbiter: registered request/grant/release arbiter that shares one
// dual-port compute RAM among NUM_CLIENTS masters, with a guard gap on handover.
// Ports:
//   clk, reset (async, active low)
//   req, rel (release pulse, owner only), grant (one-hot), owner, busy
//   cl_rd_en, cl_wr_en, cl_rd_addr, cl_wr_addr, cl_wr_data : packed per client
//   rd_sample1/2 (broadcast read data), rd_valid (per-client tag)
//   cram_* : registered RAM strobes, addresses, write data; cram_rd_data1/2 in
module cram_port_arbiter #(
    parameter int N             = 32,
    parameter int word_size     = 16,
    parameter int address_width = $clog2(N),
    parameter int NUM_CLIENTS   = 3,
    parameter int RR_MODE       = 0,
    parameter int RD_LATENCY    = 1,
    parameter int SWITCH_GAP    = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CLIENTS-1:0]                 req,
    input  logic [NUM_CLIENTS-1:0]                 rel,
    output logic [NUM_CLIENTS-1:0]                 grant,
    output logic [2:0]                             owner,
    output logic                                   busy,
    input  logic [NUM_CLIENTS-1:0]                 cl_rd_en,
    input  logic [NUM_CLIENTS-1:0]                 cl_wr_en,
    input  logic [NUM_CLIENTS*2*address_width-1:0] cl_rd_addr,
    input  logic [NUM_CLIENTS*2*address_width-1:0] cl_wr_addr,
    input  logic [NUM_CLIENTS*4*word_size-1:0]     cl_wr_data,
    output logic [2*word_size-1:0]                 rd_sample1,
    output logic [2*word_size-1:0]                 rd_sample2,
    output logic [NUM_CLIENTS-1:0]                 rd_valid,
    output logic                                   cram_rd_en,
    output logic                                   cram_wr_en,
    output logic [address_width-1:0]               cram_rd_address1,
    output logic [address_width-1:0]               cram_rd_address2,
    output logic [address_width-1:0]               cram_wr_address1,
    output logic [address_width-1:0]               cram_wr_address2,
    output logic [2*word_size-1:0]                 cram_wr_data1,
    output logic [2*word_size-1:0]                 cram_wr_data2,
    input  logic [2*word_size-1:0]                 cram_rd_data1,
    input  logic [2*word_size-1:0]                 cram_rd_data2
);

    localparam int C  = NUM_CLIENTS;
    localparam int AW = address_width;
    localparam int SW = 2 * word_size;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [C-1:0]   r_grant, w_grant_nxt;
    logic [2:0]     r_owner, w_owner_nxt;
    logic [2:0]     r_last_owner, w_last_nxt;
    logic [1:0]     r_gap, w_gap_nxt;

    logic [2*C-1:0] w_req2;
    logic [2:0]     w_base;
    logic [3:0]     w_sum;
    logic [2:0]     w_win;
    logic           w_hit;
    logic [C-1:0]   w_win_oh;

    // Rotate the request vector so the search always starts at bit 0,
    // then map the hit position back to a client index.
    always_comb begin
        w_base = '0;
        if (RR_MODE != 0) begin
            if (r_last_owner == 3'(C - 1)) begin
                w_base = '0;
            end else begin
                w_base = r_last_owner + 3'd1;
            end
        end
        w_req2 = {req, req} >> w_base;
        w_hit  = 1'b0;
        w_sum  = '0;
        w_win  = '0;
        for (int i = 0; i < C; i++) begin
            if (!w_hit && w_req2[i]) begin
                w_hit = 1'b1;
                w_sum = {1'b0, w_base} + 4'(i);
                if (w_sum >= 4'(C)) begin
                    w_sum = w_sum - 4'(C);
                end
                w_win = w_sum[2:0];
            end
        end
        w_win_oh = {{(C-1){1'b0}}, 1'b1} << w_win;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_gap_nxt   = r_gap;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_grant_nxt = w_win_oh;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Only the owner's release bit can match the one-hot grant.
                if (|(rel & r_grant)) begin
                    w_grant_nxt = '0;
                    w_gap_nxt   = 2'(SWITCH_GAP - 1);
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_gap == 2'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= 3'(C - 1);
            r_gap        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_gap        <= w_gap_nxt;
        end
    end

    logic          w_rd_en, w_wr_en;
    logic [2*AW-1:0] w_rd_addr, w_wr_addr;
    logic [2*SW-1:0] w_wr_data;
    logic          r_rd_en, r_wr_en;
    logic [2*AW-1:0] r_rd_addr, r_wr_addr;
    logic [2*SW-1:0] r_wr_data;

    // Addresses and data hold their last value when nobody owns the RAM.
    always_comb begin
        w_rd_en   = 1'b0;
        w_wr_en   = 1'b0;
        w_rd_addr = r_rd_addr;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        for (int k = 0; k < C; k++) begin
            if (r_grant[k]) begin
                w_rd_en   = cl_rd_en[k];
                w_wr_en   = cl_wr_en[k];
                w_rd_addr = cl_rd_addr[k*2*AW +: 2*AW];
                w_wr_addr = cl_wr_addr[k*2*AW +: 2*AW];
                w_wr_data = cl_wr_data[k*2*SW +: 2*SW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_rd_en   <= w_rd_en && (r_state != ST_DRAIN);
            r_wr_en   <= w_wr_en && (r_state != ST_DRAIN);
            r_rd_addr <= w_rd_addr;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
        end
    end

    // One stage for the registered strobe plus RD_LATENCY for the RAM.
    logic [C-1:0] r_vpipe [RD_LATENCY+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_vpipe[i] <= '0;
            end
        end else begin
            r_vpipe[0] <= r_grant & cl_rd_en;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    assign grant            = r_grant;
    assign owner            = r_owner;
    assign busy             = (r_state == ST_DRAIN) || (|r_grant);
    assign rd_valid         = r_vpipe[RD_LATENCY];
    assign rd_sample1       = cram_rd_data1;
    assign rd_sample2       = cram_rd_data2;
    assign cram_rd_en       = r_rd_en;
    assign cram_wr_en       = r_wr_en;
    assign cram_rd_address1 = r_rd_addr[AW-1:0];
    assign cram_rd_address2 = r_rd_addr[2*AW-1:AW];
    assign cram_wr_address1 = r_wr_addr[AW-1:0];
    assign cram_wr_address2 = r_wr_addr[2*AW-1:AW];
    assign cram_wr_data1    = r_wr_data[SW-1:0];
    assign cram_wr_data2    = r_wr_data[2*SW-1:SW];

endmodule

// File: tb/tb_cram_port_arbiter.sv
// tb_cram_port_arbiter: directed table plus hand sequences for the CRAM
// port arbiter (fixed-priority instance and a round-robin instance).
module tb_cram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, rel, cl_rd_en, cl_wr_en;
    logic [29:0] cl_rd_addr, cl_wr_addr;
    logic [191:0] cl_wr_data;
    logic [31:0] cram_rd_data1, cram_rd_data2;

    logic [2:0]  m_grant, m_owner, m_rd_valid;
    logic        m_busy, m_cram_rd_en, m_cram_wr_en;
    logic [31:0] m_rd_s1, m_rd_s2, m_wd1, m_wd2;
    logic [4:0]  m_ra1, m_ra2, m_wa1, m_wa2;

    logic [2:0]  q_grant, q_owner, q_rd_valid;
    logic        q_busy, q_cram_rd_en, q_cram_wr_en;
    logic [31:0] q_rd_s1, q_rd_s2, q_wd1, q_wd2;
    logic [4:0]  q_ra1, q_ra2, q_wa1, q_wa2;

    int n_vec = 0;
    int n_err = 0;

    cram_port_arbiter #(
        .NUM_CLIENTS(3), .RR_MODE(0), .RD_LATENCY(2), .SWITCH_GAP(2)
    ) u_fp (
        .clk(clk), .reset(reset), .req(req), .rel(rel),
        .grant(m_grant), .owner(m_owner), .busy(m_busy),
        .cl_rd_en(cl_rd_en), .cl_wr_en(cl_wr_en),
        .cl_rd_addr(cl_rd_addr), .cl_wr_addr(cl_wr_addr),
        .cl_wr_data(cl_wr_data),
        .rd_sample1(m_rd_s1), .rd_sample2(m_rd_s2), .rd_valid(m_rd_valid),
        .cram_rd_en(m_cram_rd_en), .cram_wr_en(m_cram_wr_en),
        .cram_rd_address1(m_ra1), .cram_rd_address2(m_ra2),
        .cram_wr_address1(m_wa1), .cram_wr_address2(m_wa2),
        .cram_wr_data1(m_wd1), .cram_wr_data2(m_wd2),
        .cram_rd_data1(cram_rd_data1), .cram_rd_data2(cram_rd_data2)
    );

    cram_port_arbiter #(
        .NUM_CLIENTS(3), .RR_MODE(1), .RD_LATENCY(2), .SWITCH_GAP(1)
    ) u_rr (
        .clk(clk), .reset(reset), .req(req), .rel(rel),
        .grant(q_grant), .owner(q_owner), .busy(q_busy),
        .cl_rd_en(cl_rd_en), .cl_wr_en(cl_wr_en),
        .cl_rd_addr(cl_rd_addr), .cl_wr_addr(cl_wr_addr),
        .cl_wr_data(cl_wr_data),
        .rd_sample1(q_rd_s1), .rd_sample2(q_rd_s2), .rd_valid(q_rd_valid),
        .cram_rd_en(q_cram_rd_en), .cram_wr_en(q_cram_wr_en),
        .cram_rd_address1(q_ra1), .cram_rd_address2(q_ra2),
        .cram_wr_address1(q_wa1), .cram_wr_address2(q_wa2),
        .cram_wr_data1(q_wd1), .cram_wr_data2(q_wd2),
        .cram_rd_data1(cram_rd_data1), .cram_rd_data2(cram_rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CRAM model with two-cycle read latency, attached to the fixed instance.
    logic [31:0] mem [32];
    logic [31:0] p1, p2;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
            p1 <= '0;
            p2 <= '0;
            cram_rd_data1 <= '0;
            cram_rd_data2 <= '0;
        end else begin
            if (m_cram_wr_en) begin
                mem[m_wa1] <= m_wd1;
                mem[m_wa2] <= m_wd2;
            end
            p1 <= mem[m_ra1];
            p2 <= mem[m_ra2];
            cram_rd_data1 <= p1;
            cram_rd_data2 <= p2;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] wr;
        logic [2:0] grant;
        logic [2:0] owner;
        logic       busy;
        logic       cwr;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];
    int   cnt;
    logic [2:0] exp_rr [4];

    initial begin
        // req, rel, cl_wr_en -> grant, owner, busy, cram_wr_en
        tv[0]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0};
        tv[1]  = '{3'b110, 3'b000, 3'b000, 3'b010, 3'd1, 1'b1, 1'b0};
        tv[2]  = '{3'b110, 3'b100, 3'b001, 3'b010, 3'd1, 1'b1, 1'b0};
        tv[3]  = '{3'b100, 3'b000, 3'b010, 3'b010, 3'd1, 1'b1, 1'b1};
        tv[4]  = '{3'b100, 3'b010, 3'b010, 3'b000, 3'd1, 1'b1, 1'b1};
        tv[5]  = '{3'b100, 3'b000, 3'b010, 3'b000, 3'd1, 1'b1, 1'b0};
        tv[6]  = '{3'b100, 3'b000, 3'b010, 3'b000, 3'd1, 1'b0, 1'b0};
        tv[7]  = '{3'b100, 3'b000, 3'b000, 3'b100, 3'd2, 1'b1, 1'b0};
        tv[8]  = '{3'b101, 3'b100, 3'b000, 3'b000, 3'd2, 1'b1, 1'b0};
        tv[9]  = '{3'b101, 3'b000, 3'b000, 3'b000, 3'd2, 1'b1, 1'b0};
        tv[10] = '{3'b101, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0, 1'b0};
        tv[11] = '{3'b101, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0};
        tv[12] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'd0, 1'b1, 1'b0};
        tv[13] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'd0, 1'b1, 1'b0};
        tv[14] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0};
        tv[15] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0};
        tv[16] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'd0, 1'b1, 1'b0};
        tv[17] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b1, 1'b0};
        tv[18] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0};
        exp_rr[0] = 3'b001;
        exp_rr[1] = 3'b010;
        exp_rr[2] = 3'b100;
        exp_rr[3] = 3'b001;

        reset    = 1'b0;
        req      = '0;
        rel      = '0;
        cl_rd_en = '0;
        cl_wr_en = '0;
        cl_rd_addr = {5'd10, 5'd9, 5'd6, 5'd5, 5'd2, 5'd1};
        cl_wr_addr = {5'd10, 5'd9, 5'd4, 5'd3, 5'd7, 5'd7};
        cl_wr_data = {32'h3333_0002, 32'h3333_0001,
                      32'h2222_0004, 32'h1111_0003,
                      32'hDEAD_0007, 32'hBEEF_0007};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst grant", 32'(m_grant), 32'h0);
        chk("rst owner", 32'(m_owner), 32'h0);
        chk("rst busy", 32'(m_busy), 32'h0);
        chk("rst rd_valid", 32'(m_rd_valid), 32'h0);
        chk("rst cram_wr_en", 32'(m_cram_wr_en), 32'h0);
        chk("rst cram_rd_en", 32'(m_cram_rd_en), 32'h0);
        chk("rst wr_addr1", 32'(m_wa1), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req      = tv[i].req;
            rel      = tv[i].rel;
            cl_wr_en = tv[i].wr;
            step();
            chk($sformatf("v%0d grant", i), 32'(m_grant), 32'(tv[i].grant));
            chk($sformatf("v%0d owner", i), 32'(m_owner), 32'(tv[i].owner));
            chk($sformatf("v%0d busy", i), 32'(m_busy), 32'(tv[i].busy));
            chk($sformatf("v%0d cram_wr_en", i), 32'(m_cram_wr_en),
                32'(tv[i].cwr));
        end
        chk("mem7 untouched", mem[7], 32'hA000_0007);
        chk("mem3 written", mem[3], 32'h1111_0003);
        chk("mem4 written", mem[4], 32'h2222_0004);

        // Read tagging: owner 1 reads 5/6 then releases; client 0 also strobes.
        req = 3'b010;
        step();
        chk("rd grant", 32'(m_grant), 32'h2);
        req      = 3'b000;
        cl_rd_en = 3'b011;
        step();
        chk("rd valid e1", 32'(m_rd_valid), 32'h0);
        cl_rd_en = 3'b000;
        rel      = 3'b010;
        step();
        chk("rd valid e2", 32'(m_rd_valid), 32'h0);
        chk("rd grant off", 32'(m_grant), 32'h0);
        rel = 3'b000;
        step();
        chk("rd valid e3", 32'(m_rd_valid), 32'h2);
        chk("rd sample1", m_rd_s1, 32'hA000_0005);
        chk("rd sample2", m_rd_s2, 32'hA000_0006);
        step();
        chk("rd valid e4", 32'(m_rd_valid), 32'h0);
        repeat (3) step();

        // Async reset in the middle of a granted transfer.
        req = 3'b001;
        step();
        chk("ar grant", 32'(m_grant), 32'h1);
        req      = 3'b000;
        cl_rd_en = 3'b001;
        cl_wr_en = 3'b001;
        repeat (3) step();
        chk("ar pre rd_valid", 32'(m_rd_valid), 32'h1);
        chk("ar pre cram_wr_en", 32'(m_cram_wr_en), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar grant", 32'(m_grant), 32'h0);
        chk("ar busy", 32'(m_busy), 32'h0);
        chk("ar cram_wr_en", 32'(m_cram_wr_en), 32'h0);
        chk("ar rd_valid", 32'(m_rd_valid), 32'h0);
        chk("ar rd_addr1", 32'(m_ra1), 32'h0);
        cl_rd_en = '0;
        cl_wr_en = '0;
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b001;
        step();
        chk("ar regrant", 32'(m_grant), 32'h1);
        req = 3'b000;
        rel = 3'b001;
        step();
        rel = 3'b000;

        // Round robin from a fresh reset, all clients requesting.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b111;
        for (int j = 0; j < 4; j++) begin
            cnt = 0;
            while (q_grant == 3'b000 && cnt < 10) begin
                step();
                cnt++;
            end
            chk($sformatf("rr grant %0d", j), 32'(q_grant), 32'(exp_rr[j]));
            if (j > 0) chk($sformatf("rr gap %0d", j), 32'(cnt), 32'd2);
            repeat (3) step();
            rel = exp_rr[j];
            step();
            rel = 3'b000;
        end
        req = 3'b000;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
